// File: rtl/as_sdc_requester.sv
// AS-side requester for the shutdown-circuit (SDC) controller.
// Sequences the close request, runs the watchdog square wave and latches emergencies.
module as_sdc_requester #(
   parameter int WD_HALF_PERIOD = 500,
   parameter int HB_TIMEOUT     = 2000,
   parameter int READY_TIMEOUT  = 1000,
   parameter int DEBOUNCE       = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       as_request,
   input  logic       as_mission_auto,
   input  logic       as_heartbeat,
   input  logic       sdc_is_ready,
   input  logic       shutdown_circuit,
   output logic       watchdog,
   output logic       as_close_sdc,
   output logic       as_driving_mode,
   output logic [2:0] state,
   output logic       fault,
   output logic [1:0] fault_code
);

   localparam int HBW = $clog2(HB_TIMEOUT + 1);
   localparam int RBW = $clog2(READY_TIMEOUT + 1);
   localparam int OBW = $clog2(DEBOUNCE + 1);
   localparam int WBW = $clog2(WD_HALF_PERIOD + 1);

   localparam logic [HBW-1:0] HB_MAX    = HBW'(HB_TIMEOUT);
   localparam logic [RBW-1:0] RDY_MAX   = RBW'(READY_TIMEOUT);
   localparam logic [RBW-1:0] RDY_LAST  = RBW'(READY_TIMEOUT - 1);
   localparam logic [OBW-1:0] OPEN_MAX  = OBW'(DEBOUNCE);
   localparam logic [OBW-1:0] OPEN_LAST = OBW'(DEBOUNCE - 1);
   localparam logic [WBW-1:0] WD_LAST   = WBW'(WD_HALF_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQUEST   = 3'd1,
      S_WAIT      = 3'd2,
      S_CLOSED    = 3'd3,
      S_EMERGENCY = 3'd4
   } state_t;

   state_t         cur, nxt;
   logic [1:0]     nxt_fc;
   logic [HBW-1:0] hb_cnt;
   logic [RBW-1:0] rdy_cnt;
   logic [OBW-1:0] open_cnt;
   logic [WBW-1:0] wd_div;
   logic           hb_alive, rdy_hit, open_hit;

   assign hb_alive = (hb_cnt < HB_MAX);
   // Hit flags look at the value the counter reaches on this edge.
   assign rdy_hit  = (rdy_cnt >= RDY_LAST);
   assign open_hit = !shutdown_circuit && (open_cnt >= OPEN_LAST);
   assign state    = cur;

   always_comb begin
      nxt    = cur;
      nxt_fc = fault_code;
      case (cur)
         S_IDLE: if (as_request && hb_alive) nxt = S_REQUEST;
         S_REQUEST: begin
            if (!hb_alive)        begin nxt = S_EMERGENCY; nxt_fc = 2'b11; end
            else if (!as_request) nxt = S_IDLE;
            else                  nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!hb_alive)         begin nxt = S_EMERGENCY; nxt_fc = 2'b11; end
            else if (rdy_hit)      begin nxt = S_EMERGENCY; nxt_fc = 2'b01; end
            else if (sdc_is_ready) nxt = S_CLOSED;
            else if (!as_request)  nxt = S_IDLE;
         end
         S_CLOSED: begin
            if (!hb_alive)        begin nxt = S_EMERGENCY; nxt_fc = 2'b11; end
            else if (open_hit)    begin nxt = S_EMERGENCY; nxt_fc = 2'b10; end
            else if (!as_request) nxt = S_IDLE;
         end
         S_EMERGENCY: nxt = S_EMERGENCY;
         default:     nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cur             <= S_IDLE;
         as_close_sdc    <= 1'b0;
         as_driving_mode <= 1'b0;
         fault           <= 1'b0;
         fault_code      <= 2'b00;
      end else begin
         cur          <= nxt;
         as_close_sdc <= (nxt == S_REQUEST) || (nxt == S_WAIT) || (nxt == S_CLOSED);
         fault        <= fault || (nxt == S_EMERGENCY);
         fault_code   <= nxt_fc;
         if (cur == S_IDLE && nxt == S_REQUEST)
            as_driving_mode <= as_mission_auto;
         else if (nxt == S_IDLE || nxt == S_EMERGENCY)
            as_driving_mode <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hb_cnt   <= '0;
         rdy_cnt  <= '0;
         open_cnt <= '0;
      end else begin
         if (as_heartbeat)          hb_cnt <= '0;
         else if (hb_cnt < HB_MAX)  hb_cnt <= hb_cnt + 1'b1;

         if (cur != S_WAIT)          rdy_cnt <= '0;
         else if (rdy_cnt < RDY_MAX) rdy_cnt <= rdy_cnt + 1'b1;

         if (cur != S_CLOSED || shutdown_circuit) open_cnt <= '0;
         else if (open_cnt < OPEN_MAX)            open_cnt <= open_cnt + 1'b1;
      end
   end

   // Gate on the next state so the wave stops on the same edge EMERGENCY is entered.
   always_ff @(posedge clk) begin
      if (reset || !hb_alive || nxt == S_EMERGENCY) begin
         watchdog <= 1'b0;
         wd_div   <= '0;
      end else if (wd_div >= WD_LAST) begin
         watchdog <= !watchdog;
         wd_div   <= '0;
      end else begin
         wd_div <= wd_div + 1'b1;
      end
   end

endmodule

// File: tb/tb_as_sdc_requester.sv
// Scoreboard bench for as_sdc_requester: the driver queues expected state transitions,
// the monitor checks each transition (outputs and edge number) as the DUT makes it.
module tb_as_sdc_requester;

   logic       clk = 1'b0;
   logic       reset, as_request, as_mission_auto, as_heartbeat, sdc_is_ready, shutdown_circuit;
   logic       watchdog, as_close_sdc, as_driving_mode, fault;
   logic [2:0] state;
   logic [1:0] fault_code;

   as_sdc_requester #(
      .WD_HALF_PERIOD(4), .HB_TIMEOUT(50), .READY_TIMEOUT(20), .DEBOUNCE(3)
   ) dut (
      .clk(clk), .reset(reset), .as_request(as_request), .as_mission_auto(as_mission_auto),
      .as_heartbeat(as_heartbeat), .sdc_is_ready(sdc_is_ready), .shutdown_circuit(shutdown_circuit),
      .watchdog(watchdog), .as_close_sdc(as_close_sdc), .as_driving_mode(as_driving_mode),
      .state(state), .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] st;
      logic       cl, dm, f;
      logic [1:0] fc;
      int         c;   // expected edge number, -1 = any
   } exp_t;

   exp_t       q[$];
   exp_t       me;
   int         tests = 0, fails = 0;
   int         cyc = 0, hb_last = 0;
   bit         hb_en = 1'b1, mon_en = 1'b0;
   logic [2:0] prev = 3'd0;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      as_heartbeat = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (hb_en && cyc % 10 == 0) begin
            as_heartbeat = 1'b1;
            hb_last      = cyc + 1;
         end else begin
            as_heartbeat = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en && state !== prev) begin
         tests++;
         if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_transition: state %0d -> %0d at edge %0d, none expected", prev, state, cyc);
         end else begin
            me = q.pop_front();
            if (state !== me.st || as_close_sdc !== me.cl || as_driving_mode !== me.dm ||
                fault !== me.f || fault_code !== me.fc || (me.c >= 0 && cyc != me.c)) begin
               fails++;
               $display("FAIL transition: got st=%0d close=%0b dm=%0b fault=%0b fc=%0d edge=%0d, want st=%0d close=%0b dm=%0b fault=%0b fc=%0d edge=%0d",
                        state, as_close_sdc, as_driving_mode, fault, fault_code, cyc,
                        me.st, me.cl, me.dm, me.f, me.fc, me.c);
            end
         end
      end
      if (mon_en) prev = state;
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic [2:0] st, input logic cl, dm, f, input logic [1:0] fc, input int c);
      exp_t e;
      e.st = st; e.cl = cl; e.dm = dm; e.f = f; e.fc = fc; e.c = c;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic go(input logic auto, output int k);
      k               = cyc;
      as_mission_auto = auto;
      as_request      = 1'b1;
      push(3'd1, 1'b1, auto, 1'b0, 2'd0, k + 1);
      push(3'd2, 1'b1, auto, 1'b0, 2'd0, k + 2);
   endtask

   task automatic do_reset();
      as_request = 1'b0;
      push(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, cyc + 1);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      step(1);
   endtask

   task automatic wait_mod5();
      int n = 0;
      while (cyc % 10 != 5 && n < 20) begin step(1); n++; end
   endtask

   task automatic wd_period(input string name);
      logic w;
      int   t0, n;
      w = watchdog; n = 0;
      while (watchdog === w && n < 20) begin step(1); n++; end
      t0 = cyc; w = watchdog; n = 0;
      while (watchdog === w && n < 20) begin step(1); n++; end
      chk(name, cyc - t0, 4);
   endtask

   initial begin
      int k, l, bad;
      reset = 1'b1; as_request = 1'b0; as_mission_auto = 1'b0;
      sdc_is_ready = 1'b0; shutdown_circuit = 1'b1;
      step(3);
      chk("rst_state", state, 0);
      chk("rst_watchdog", watchdog, 0);
      chk("rst_close", as_close_sdc, 0);
      chk("rst_mode", as_driving_mode, 0);
      chk("rst_fault", fault, 0);
      chk("rst_fault_code", fault_code, 0);
      reset = 1'b0;
      mon_en = 1'b1;
      step(2);

      // nominal close, ready five cycles after REQUEST
      go(1'b1, k);
      push(3'd3, 1'b1, 1'b1, 1'b0, 2'd0, k + 6);
      step(5);
      sdc_is_ready = 1'b1;
      step(2);
      wd_period("wd_half_period_a");
      wd_period("wd_half_period_b");
      push(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, cyc + 1);
      as_request = 1'b0;
      step(3);

      // ready timeout
      sdc_is_ready = 1'b0;
      go(1'b0, k);
      push(3'd4, 1'b0, 1'b0, 1'b1, 2'd1, k + 22);
      step(23);
      bad = 0;
      repeat (10) begin if (watchdog !== 1'b0) bad++; step(1); end
      chk("emerg_watchdog_stuck", bad, 0);
      do_reset();

      // SDC open: two low samples tolerated, three trip
      sdc_is_ready = 1'b1;
      go(1'b0, k);
      push(3'd3, 1'b1, 1'b0, 1'b0, 2'd0, k + 3);
      step(5);
      shutdown_circuit = 1'b0;
      step(2);
      shutdown_circuit = 1'b1;
      step(5);
      push(3'd4, 1'b0, 1'b0, 1'b1, 2'd2, cyc + 3);
      shutdown_circuit = 1'b0;
      step(5);
      shutdown_circuit = 1'b1;
      do_reset();

      // heartbeat loss while CLOSED
      go(1'b1, k);
      push(3'd3, 1'b1, 1'b1, 1'b0, 2'd0, k + 3);
      step(4);
      wait_mod5();
      hb_en = 1'b0;
      l = hb_last;
      push(3'd4, 1'b0, 1'b0, 1'b1, 2'd3, l + 51);
      step(60);
      wait_mod5();
      hb_en = 1'b1;
      do_reset();

      // heartbeat loss in IDLE: watchdog stops, no fault, requests ignored
      wait_mod5();
      hb_en = 1'b0;
      step(55);
      bad = 0;
      repeat (8) begin if (watchdog !== 1'b0 || fault !== 1'b0) bad++; step(1); end
      chk("idle_hbloss_quiet", bad, 0);
      as_mission_auto = 1'b0;
      as_request = 1'b1;
      step(5);
      chk("idle_hbloss_no_request", state, 0);
      push(3'd1, 1'b1, 1'b0, 1'b0, 2'd0, -1);
      push(3'd2, 1'b1, 1'b0, 1'b0, 2'd0, -1);
      push(3'd3, 1'b1, 1'b0, 1'b0, 2'd0, -1);
      wait_mod5();
      hb_en = 1'b1;
      step(20);
      push(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, cyc + 1);
      as_request = 1'b0;
      step(3);

      // heartbeat loss and third open sample on the same edge
      go(1'b1, k);
      push(3'd3, 1'b1, 1'b1, 1'b0, 2'd0, k + 3);
      step(4);
      wait_mod5();
      hb_en = 1'b0;
      l = hb_last;
      while (cyc < l + 48) step(1);
      shutdown_circuit = 1'b0;
      push(3'd4, 1'b0, 1'b0, 1'b1, 2'd3, l + 51);
      step(8);
      shutdown_circuit = 1'b1;
      wait_mod5();
      hb_en = 1'b1;
      do_reset();
      chk("post_reset_fault", fault, 0);
      chk("post_reset_code", fault_code, 0);

      // request after recovery
      go(1'b1, k);
      push(3'd3, 1'b1, 1'b1, 1'b0, 2'd0, k + 3);
      step(6);
      push(3'd0, 1'b0, 1'b0, 1'b0, 2'd0, cyc + 1);
      as_request = 1'b0;
      step(3);

      while (q.size() > 0) begin
         me = q.pop_front();
         tests++;
         fails++;
         $display("FAIL missing_transition: got none, want st=%0d edge=%0d", me.st, me.c);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/as_sdc_requester.md
AS_SDC_REQUESTER -- requirements
Module: as_sdc_requester

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameters SHALL be (name, default, meaning):
- WD_HALF_PERIOD, 500: clk cycles per watchdog half period.
- HB_TIMEOUT, 2000: max clk cycles allowed between as_heartbeat pulses.
- READY_TIMEOUT, 1000: max clk cycles in WAIT_READY.
- DEBOUNCE, 4: consecutive low samples of shutdown_circuit that count as an open SDC.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- as_request, in, 1: AS computer requests the SDC closed (level).
- as_mission_auto, in, 1: autonomous mission selected.
- as_heartbeat, in, 1: single-cycle liveness pulse from the AS computer.
- sdc_is_ready, in, 1: ready flag from the SDC controller.
- shutdown_circuit, in, 1: SDC loop feedback; 1 = closed.
- watchdog, out, 1: square wave to the SDC controller watchdog input.
- as_close_sdc, out, 1: close request to the SDC controller.
- as_driving_mode, out, 1: latched driving mode to the SDC controller.
- state, out, 3: current FSM state code.
- fault, out, 1: sticky emergency flag.
- fault_code, out, 2: cause of the emergency.

Function
REQ-004 The FSM SHALL have these states and codes: IDLE=0, REQUEST=1, WAIT_READY=2, CLOSED=3, EMERGENCY=4.
REQ-005 A heartbeat counter SHALL clear on as_heartbeat=1 and otherwise increment, saturating at HB_TIMEOUT.
REQ-006 hb_alive SHALL be 1 while the heartbeat counter is below HB_TIMEOUT.
REQ-007 IDLE -> REQUEST SHALL occur when as_request=1 and hb_alive=1.
REQ-008 On entering REQUEST, as_driving_mode SHALL latch as_mission_auto, and SHALL hold that value until the FSM next returns to IDLE.
REQ-009 REQUEST SHALL last exactly one cycle, then go to WAIT_READY with the ready counter cleared.
REQ-010 as_close_sdc SHALL be 1 in REQUEST, WAIT_READY and CLOSED, and 0 in every other state.
REQ-011 In WAIT_READY, the ready counter SHALL increment every cycle.
- sdc_is_ready=1 -> CLOSED next cycle.
- Counter reaching READY_TIMEOUT -> EMERGENCY with fault_code=01.
REQ-012 In CLOSED, an open-loop counter SHALL count consecutive cycles with shutdown_circuit=0.
- Counter reaching DEBOUNCE -> EMERGENCY with fault_code=10.
- Any cycle with shutdown_circuit=1 clears the counter.
REQ-013 In REQUEST, WAIT_READY or CLOSED, as_request=0 SHALL return the FSM to IDLE next cycle, and as_driving_mode SHALL clear.
REQ-014 hb_alive=0 SHALL force EMERGENCY with fault_code=11 from any non-EMERGENCY state other than IDLE.
REQ-015 In IDLE, hb_alive=0 SHALL only stop the watchdog; it SHALL NOT raise a fault.
REQ-016 When events coincide in one cycle, priority SHALL be: heartbeat loss > SDC open > ready timeout > sdc_is_ready > as_request drop.
REQ-017 EMERGENCY SHALL be absorbing: as_close_sdc=0, as_driving_mode=0, fault=1, watchdog=0; exit is by reset only.
REQ-018 While hb_alive=1 and state != EMERGENCY, watchdog SHALL toggle every WD_HALF_PERIOD cycles.
REQ-019 When hb_alive=0 or state=EMERGENCY, watchdog SHALL be held at 0 and its divider cleared.
REQ-020 All outputs SHALL be registered, with one-cycle latency from the qualifying input sample.
REQ-021 All counters SHALL saturate and never wrap.

Reset
REQ-022 On reset=1 at a clk edge, the following SHALL be cleared: state=IDLE, watchdog=0, as_close_sdc=0, as_driving_mode=0, fault=0, fault_code=00, and all counters (heartbeat counter at 0, so hb_alive=1).
REQ-023 Reset asserted mid-operation, including in EMERGENCY, SHALL take priority over every transition in that cycle.

Verification (WD_HALF_PERIOD=4, HB_TIMEOUT=50, READY_TIMEOUT=20, DEBOUNCE=3; heartbeat every 10 cycles unless stated)
REQ-024 Nominal: as_request=1, as_mission_auto=1, sdc_is_ready=1 five cycles after REQUEST -> states 1,2,3; as_close_sdc=1 and as_driving_mode=1 from the REQUEST cycle; watchdog toggles every 4 cycles.
REQ-025 Ready timeout: sdc_is_ready held at 0 -> EMERGENCY 20 cycles after entering WAIT_READY, fault_code=01, as_close_sdc=0, watchdog stuck at 0.
REQ-026 SDC open: in CLOSED, shutdown_circuit=0 for 2 cycles then 1 -> stays CLOSED; shutdown_circuit=0 for 3 cycles -> EMERGENCY, fault_code=10.
REQ-027 Heartbeat loss: heartbeats stop while CLOSED -> EMERGENCY 50 cycles after the last pulse, fault_code=11; the same loss in IDLE -> watchdog stops, fault=0.
REQ-028 Simultaneous events and reset: heartbeat loss and shutdown_circuit open in the same cycle -> fault_code=11. Reset pulse in EMERGENCY -> IDLE with all outputs 0; a new request then succeeds.
